// File: rtl/seg_serial_rx_pkg.sv
// Shared types and constants for the 7-segment serial link receiver.
// Glyph table is indexed by hex value; segment bit0 = a ... bit6 = g, bit7 = dp.
package seg_serial_rx_pkg;

    localparam int FRAME_BITS_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT_LOW
    } rx_state_e;

    // Entry g is the lit-segment pattern (active-high) for hex digit g.
    localparam logic [15:0][7:0] SEG_GLYPHS = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

endpackage

// File: rtl/seg_serial_rx_decode.sv
// Combinational 7-segment glyph decoder: normalised pattern in, hex nibble out.
// Unrecognised glyphs decode to 0 with ok low; dp is passed through.
module seg7_decode
    import seg_serial_rx_pkg::*;
(
    input  logic [7:0] pattern,
    output logic [3:0] digit,
    output logic       ok,
    output logic       dp
);

    always_comb begin
        digit = 4'd0;
        ok    = 1'b0;
        dp    = pattern[7];
        for (int g = 0; g < 16; g++) begin
            if (pattern[6:0] == SEG_GLYPHS[g][6:0]) begin
                digit = 4'(g);
                ok    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_serial_rx.sv
// Receiver for the SEG_CLK/SEG_DO/SEG_EN serial display link: captures a frame,
// length-checks it, latches it and decodes each byte back to a hex digit.
module seg_serial_rx
    import seg_serial_rx_pkg::*;
#(
    parameter int FRAME_BITS     = FRAME_BITS_DEF,
    parameter int TIMEOUT        = 1024,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    seg_clk,
    input  logic                    seg_do,
    input  logic                    seg_en,
    output logic [FRAME_BITS-1:0]   frame,
    output logic                    frame_valid,
    output logic                    frame_err,
    output logic [FRAME_BITS/2-1:0] digits,
    output logic [FRAME_BITS/8-1:0] digit_ok,
    output logic [FRAME_BITS/8-1:0] dp,
    output logic                    busy
);

    localparam int NB    = FRAME_BITS / 8;
    localparam int CNT_W = $clog2(2 * FRAME_BITS);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2 * FRAME_BITS - 1);

    rx_state_e             state;
    logic [2:0]            clk_sync;
    logic [2:0]            en_sync;
    logic [1:0]            do_sync;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [FRAME_BITS-1:0] shift_nxt;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [TO_W-1:0]       to_cnt;

    logic [NB-1:0][3:0]    dec_digits;
    logic [NB-1:0]         dec_ok;
    logic [NB-1:0]         dec_dp;

    logic clk_rise, en_rise, en_fall, sdo;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= '0;
            en_sync  <= '0;
            do_sync  <= '0;
        end else begin
            clk_sync <= {clk_sync[1:0], seg_clk};
            en_sync  <= {en_sync[1:0], seg_en};
            do_sync  <= {do_sync[0], seg_do};
        end
    end

    assign clk_rise = clk_sync[1] & ~clk_sync[2];
    assign en_rise  = en_sync[1] & ~en_sync[2];
    assign en_fall  = ~en_sync[1] & en_sync[2];
    assign sdo      = do_sync[1];

    // Next shift/count include a bit arriving in the same cycle as seg_en falling.
    always_comb begin
        shift_nxt = shift_reg;
        cnt_nxt   = bit_cnt;
        if (clk_rise) begin
            shift_nxt = {shift_reg[FRAME_BITS-2:0], sdo};
            if (bit_cnt != CNT_MAX) cnt_nxt = bit_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NB; i++) begin : g_dec
        logic [7:0] pat;
        assign pat = SEG_ACTIVE_LOW ? ~shift_nxt[8*i +: 8] : shift_nxt[8*i +: 8];
        seg7_decode u_dec (
            .pattern (pat),
            .digit   (dec_digits[i]),
            .ok      (dec_ok[i]),
            .dp      (dec_dp[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            to_cnt      <= '0;
            frame       <= '0;
            digits      <= '0;
            digit_ok    <= '0;
            dp          <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en_rise) begin
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        to_cnt    <= '0;
                        busy      <= 1'b1;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shift_reg <= shift_nxt;
                    bit_cnt   <= cnt_nxt;
                    if (en_fall) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                        if (cnt_nxt == CNT_W'(FRAME_BITS)) begin
                            frame       <= shift_nxt;
                            digits      <= dec_digits;
                            digit_ok    <= dec_ok;
                            dp          <= dec_dp;
                            frame_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else if (clk_rise) begin
                        to_cnt <= '0;
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                        to_cnt    <= '0;
                        state     <= ST_WAIT_LOW;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!en_sync[1]) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_serial_rx.sv
// Directed bench for seg_serial_rx: one active-high and one active-low instance
// share the serial inputs; each task checks its own scenario.
module tb_seg_serial_rx;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic seg_clk = 1'b0;
    logic seg_do = 1'b0;
    logic seg_en = 1'b0;

    logic [63:0] hi_frame, lo_frame;
    logic        hi_valid, lo_valid, hi_err, lo_err, hi_busy, lo_busy;
    logic [31:0] hi_digits, lo_digits;
    logic [7:0]  hi_ok, lo_ok, hi_dp, lo_dp;

    int tests = 0;
    int fails = 0;
    int hi_vld_cnt = 0, hi_err_cnt = 0, lo_vld_cnt = 0, lo_err_cnt = 0;

    always #5 clk = ~clk;

    seg_serial_rx #(.FRAME_BITS(64), .TIMEOUT(1024), .SEG_ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .reset(reset), .seg_clk(seg_clk), .seg_do(seg_do), .seg_en(seg_en),
        .frame(hi_frame), .frame_valid(hi_valid), .frame_err(hi_err),
        .digits(hi_digits), .digit_ok(hi_ok), .dp(hi_dp), .busy(hi_busy)
    );

    seg_serial_rx #(.FRAME_BITS(64), .TIMEOUT(1024), .SEG_ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .reset(reset), .seg_clk(seg_clk), .seg_do(seg_do), .seg_en(seg_en),
        .frame(lo_frame), .frame_valid(lo_valid), .frame_err(lo_err),
        .digits(lo_digits), .digit_ok(lo_ok), .dp(lo_dp), .busy(lo_busy)
    );

    always @(negedge clk) begin
        if (hi_valid) hi_vld_cnt++;
        if (hi_err)   hi_err_cnt++;
        if (lo_valid) lo_vld_cnt++;
        if (lo_err)   lo_err_cnt++;
    end

    // Sends the low n bits of data MSB first; seg_clk half-period is 4 clk cycles.
    task automatic send_bits(input logic [127:0] data, input int n, input bit drop_en);
        @(negedge clk);
        seg_en = 1'b1;
        repeat (4) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            seg_do = data[n-1-k];
            repeat (4) @(negedge clk);
            seg_clk = 1'b1;
            repeat (4) @(negedge clk);
            seg_clk = 1'b0;
        end
        repeat (4) @(negedge clk);
        if (drop_en) seg_en = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({hi_frame, hi_digits, hi_ok, hi_dp} !== 112'd0) begin
            fails++; $display("FAIL reset_hi_data: got %h expected 0", {hi_frame, hi_digits, hi_ok, hi_dp});
        end
        tests++;
        if ({hi_valid, hi_err, hi_busy, lo_valid, lo_err, lo_busy} !== 6'd0) begin
            fails++; $display("FAIL reset_flags: got %b expected 000000",
                              {hi_valid, hi_err, hi_busy, lo_valid, lo_err, lo_busy});
        end
        tests++;
        if ({lo_frame, lo_digits, lo_ok, lo_dp} !== 112'd0) begin
            fails++; $display("FAIL reset_lo_data: got %h expected 0", {lo_frame, lo_digits, lo_ok, lo_dp});
        end
    endtask

    task automatic test_active_high;
        int v0 = hi_vld_cnt;
        send_bits(128'h3F065B4F666D7D07, 64, 1'b1);
        repeat (2) @(negedge clk);
        tests++;
        if (hi_valid !== 1'b0) begin
            fails++; $display("FAIL latency_early: got %b expected 0", hi_valid);
        end
        @(negedge clk);
        tests++;
        if (hi_valid !== 1'b1) begin
            fails++; $display("FAIL latency_pulse: got %b expected 1", hi_valid);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (hi_frame !== 64'h3F065B4F666D7D07) begin
            fails++; $display("FAIL hi_frame: got %h expected 3f065b4f666d7d07", hi_frame);
        end
        tests++;
        if (hi_digits !== 32'h01234567) begin
            fails++; $display("FAIL hi_digits: got %h expected 01234567", hi_digits);
        end
        tests++;
        if (hi_ok !== 8'hFF || hi_dp !== 8'h00) begin
            fails++; $display("FAIL hi_ok_dp: got %h/%h expected ff/00", hi_ok, hi_dp);
        end
        tests++;
        if (hi_vld_cnt - v0 !== 1) begin
            fails++; $display("FAIL hi_valid_count: got %0d expected 1", hi_vld_cnt - v0);
        end
    endtask

    task automatic test_active_low;
        send_bits(128'hC0C0C0C0C040C0C0, 64, 1'b1);
        repeat (8) @(negedge clk);
        tests++;
        if (lo_frame !== 64'hC0C0C0C0C040C0C0) begin
            fails++; $display("FAIL lo_frame: got %h expected c0c0c0c0c040c0c0", lo_frame);
        end
        tests++;
        if (lo_digits !== 32'h0 || lo_ok !== 8'hFF) begin
            fails++; $display("FAIL lo_digits_ok: got %h/%h expected 00000000/ff", lo_digits, lo_ok);
        end
        tests++;
        if (lo_dp !== 8'h04) begin
            fails++; $display("FAIL lo_dp: got %h expected 04", lo_dp);
        end
    endtask

    task automatic test_bad_byte;
        send_bits(128'h3F065B4F006D7D07, 64, 1'b1);
        repeat (8) @(negedge clk);
        tests++;
        if (hi_digits !== 32'h01230567) begin
            fails++; $display("FAIL bad_byte_digits: got %h expected 01230567", hi_digits);
        end
        tests++;
        if (hi_ok !== 8'hF7) begin
            fails++; $display("FAIL bad_byte_ok: got %h expected f7", hi_ok);
        end
    endtask

    task automatic test_length_err;
        int v0 = hi_vld_cnt;
        int e0 = hi_err_cnt;
        send_bits(128'h7FFF_FFFF_FFFF_FFFF, 63, 1'b1);
        repeat (8) @(negedge clk);
        send_bits(128'h1_0000_0000_0000_0000, 65, 1'b1);
        repeat (8) @(negedge clk);
        tests++;
        if (hi_err_cnt - e0 !== 2) begin
            fails++; $display("FAIL len_err_count: got %0d expected 2", hi_err_cnt - e0);
        end
        tests++;
        if (hi_vld_cnt - v0 !== 0) begin
            fails++; $display("FAIL len_valid_count: got %0d expected 0", hi_vld_cnt - v0);
        end
        tests++;
        if (hi_frame !== 64'h3F065B4F006D7D07) begin
            fails++; $display("FAIL len_frame_held: got %h expected 3f065b4f006d7d07", hi_frame);
        end
    endtask

    task automatic test_timeout;
        int v0 = hi_vld_cnt;
        int e0 = hi_err_cnt;
        send_bits(128'h2AA, 10, 1'b0);
        tests++;
        if (hi_busy !== 1'b1) begin
            fails++; $display("FAIL to_busy_shift: got %b expected 1", hi_busy);
        end
        repeat (1100) @(negedge clk);
        tests++;
        if (hi_err_cnt - e0 !== 1 || hi_busy !== 1'b0) begin
            fails++; $display("FAIL to_err: got cnt %0d busy %b expected 1/0", hi_err_cnt - e0, hi_busy);
        end
        for (int k = 0; k < 3; k++) begin
            repeat (4) @(negedge clk);
            seg_clk = 1'b1;
            repeat (4) @(negedge clk);
            seg_clk = 1'b0;
        end
        seg_en = 1'b0;
        repeat (10) @(negedge clk);
        tests++;
        if (hi_err_cnt - e0 !== 1 || hi_vld_cnt - v0 !== 0 || hi_busy !== 1'b0) begin
            fails++; $display("FAIL to_wait_low: got err %0d vld %0d busy %b expected 1/0/0",
                              hi_err_cnt - e0, hi_vld_cnt - v0, hi_busy);
        end
        send_bits(128'h7F6F777C395E7971, 64, 1'b1);
        repeat (8) @(negedge clk);
        tests++;
        if (hi_vld_cnt - v0 !== 1 || hi_digits !== 32'h89ABCDEF || hi_ok !== 8'hFF) begin
            fails++; $display("FAIL to_recover: got vld %0d digits %h ok %h expected 1/89abcdef/ff",
                              hi_vld_cnt - v0, hi_digits, hi_ok);
        end
    endtask

    task automatic test_reset_mid_frame;
        int v0, e0;
        send_bits(128'h3FFF_FFFF, 30, 1'b0);
        reset  = 1'b1;
        seg_en = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        v0 = hi_vld_cnt;
        e0 = hi_err_cnt;
        repeat (4) @(negedge clk);
        tests++;
        if (hi_frame !== 64'd0 || hi_busy !== 1'b0) begin
            fails++; $display("FAIL rst_mid_clear: got %h busy %b expected 0/0", hi_frame, hi_busy);
        end
        send_bits(128'h066D7D073F5B4F66, 64, 1'b1);
        repeat (8) @(negedge clk);
        tests++;
        if (hi_err_cnt - e0 !== 0 || hi_vld_cnt - v0 !== 1) begin
            fails++; $display("FAIL rst_mid_pulses: got err %0d vld %0d expected 0/1",
                              hi_err_cnt - e0, hi_vld_cnt - v0);
        end
        tests++;
        if (hi_frame !== 64'h066D7D073F5B4F66 || hi_digits !== 32'h15670234) begin
            fails++; $display("FAIL rst_mid_data: got %h/%h expected 066d7d073f5b4f66/15670234",
                              hi_frame, hi_digits);
        end
    endtask

    task automatic test_back_to_back;
        int v0 = hi_vld_cnt;
        int e0 = hi_err_cnt;
        send_bits(128'h0606060606060606, 64, 1'b1);
        @(negedge clk);
        send_bits(128'h3F3F3F3F3F3F3F06, 64, 1'b1);
        repeat (8) @(negedge clk);
        tests++;
        if (hi_vld_cnt - v0 !== 2 || hi_err_cnt - e0 !== 0) begin
            fails++; $display("FAIL b2b_pulses: got vld %0d err %0d expected 2/0",
                              hi_vld_cnt - v0, hi_err_cnt - e0);
        end
        tests++;
        if (hi_digits !== 32'h00000001) begin
            fails++; $display("FAIL b2b_digits: got %h expected 00000001", hi_digits);
        end
    endtask

    initial begin
        test_reset;
        test_active_high;
        test_active_low;
        test_bad_byte;
        test_length_err;
        test_timeout;
        test_reset_mid_frame;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
